// File: rtl/adder4_rr_sched.sv
// Round-robin front end for a shared (W+2)-bit adder: each requester submits
// {d,c,b,a} and gets back a+b+c+d after three accumulate cycles.
//
//  state | meaning
//  IDLE  | arbitrating; req_ready asserted toward the granted requester
//  ACC   | three sequential adds of b, c, d into acc (step 0..2)
//  DONE  | result held on rsp_* until the consumer takes it
module adder4_rr_sched #(
   parameter int NREQ = 2,
   parameter int W    = 8,
   parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*4*W-1:0]   req_data,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [W+1:0]          rsp_sum,
   output logic [IDW-1:0]        rsp_id,
   output logic                  busy
);

   typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

   state_t         state, state_nxt;
   logic [IDW-1:0] rr_ptr, grant, ptr_nxt;
   logic           found, accept, last_add;
   logic [W+1:0]   acc, add_in, add_out;
   logic [W-1:0]   op_b, op_c, op_d;
   logic [1:0]     step;
   logic [4*W-1:0] grant_data;

   // Rotating priority scan starting at rr_ptr.
   always_comb begin
      grant = '0;
      found = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (!found && req_valid[(int'(rr_ptr) + i) % NREQ]) begin
            found = 1'b1;
            grant = IDW'((int'(rr_ptr) + i) % NREQ);
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (rst_n && state == IDLE && found)
         req_ready[grant] = 1'b1;
   end

   assign grant_data = req_data[int'(grant)*4*W +: 4*W];
   assign ptr_nxt    = (grant == IDW'(NREQ-1)) ? '0 : grant + 1'b1;
   assign busy       = (state != IDLE);

   // The single shared adder; operand order b, c, d by step.
   always_comb begin
      case (step)
         2'd0:    add_in = {2'b00, op_b};
         2'd1:    add_in = {2'b00, op_c};
         default: add_in = {2'b00, op_d};
      endcase
   end
   assign add_out = acc + add_in;

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      last_add  = 1'b0;
      case (state)
         IDLE: begin
            accept = |(req_valid & req_ready);
            if (accept) state_nxt = ACC;
         end
         ACC: begin
            last_add = (step == 2'd2);
            if (last_add) state_nxt = DONE;
         end
         DONE: begin
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr    <= '0;
         acc       <= '0;
         step      <= '0;
         op_b      <= '0;
         op_c      <= '0;
         op_d      <= '0;
         rsp_valid <= 1'b0;
         rsp_sum   <= '0;
         rsp_id    <= '0;
      end else begin
         if (accept) begin
            acc    <= {2'b00, grant_data[W-1:0]};
            op_b   <= grant_data[2*W-1:W];
            op_c   <= grant_data[3*W-1:2*W];
            op_d   <= grant_data[4*W-1:3*W];
            rsp_id <= grant;
            rr_ptr <= ptr_nxt;
            step   <= '0;
         end
         if (state == ACC) begin
            acc  <= add_out;
            step <= step + 2'd1;
         end
         if (last_add) begin
            rsp_valid <= 1'b1;
            rsp_sum   <= add_out;
         end
         if (state == DONE && rsp_ready)
            rsp_valid <= 1'b0;
      end
   end

endmodule

// File: doc/adder4_rr_sched.md
Name: adder4_rr_sched

Overview:
- Shares one (W+2)-bit two-input adder among NREQ requesters, each submitting a four-operand sum (a+b+c+d).
- Round-robin arbitration picks one request and latches its operands, then sequences the adder over three accumulate cycles.
- Result returns on a registered valid/ready response channel tagged with the requester index.
- Sits in front of the shared datapath adder, replacing per-requester four-input adder trees.

Parameters:
- NREQ, 2, number of requesters, ≥1.
- W, 8, operand width in bits; result width is W+2.
- IDW, $clog2(NREQ) (min 1), width of the requester index.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high.
- req_data  in  NREQ*4*W  per requester i, bits [i*4W +: 4W], packed {d,c,b,a}; a in the LSBs.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer ready.
- rsp_sum  out  W+2  a+b+c+d, unsigned, zero-extended operands.
- rsp_id  out  IDW  index of the requester that produced rsp_sum.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - state=IDLE, rr_ptr=0, acc=0, step=0.
  - rsp_valid=0, rsp_sum=0, rsp_id=0, busy=0.
  - req_ready is 0 while rst_n is low.
- Arbitration (combinational, IDLE only):
  - Scan req_valid starting at rr_ptr, ascending and wrapping; the first set bit is the grant.
  - req_ready[grant]=1. All req_ready bits are 0 outside IDLE or when no req_valid is set.
- Accept edge k (IDLE and req_valid[g]&req_ready[g]):
  - Latch b,c,d of requester g into the operand regs; acc <= zero-extended a; rsp_id <= g.
  - rr_ptr <= (g+1) mod NREQ; state <= ACC; step <= 0.
- ACC:
  - Edges k+1, k+2, k+3 perform acc <= acc + op[step], with op order b, c, d.
  - Exactly one adder operation per cycle.
  - After the third add (edge k+3): state <= DONE, rsp_valid <= 1, rsp_sum <= final acc.
- Latency: rsp_valid is first high in the cycle after edge k+3, i.e. 4 cycles after accept.
- DONE:
  - rsp_valid, rsp_sum and rsp_id stay stable until rsp_valid&rsp_ready is sampled.
  - On that edge: rsp_valid <= 0, state <= IDLE.
  - No same-cycle re-accept: the next accept can happen at the earliest on the following edge.
  - Peak throughput is 1 result per 5 cycles.
- Width: maximum sum 4*(2^W-1) < 2^(W+2), so the result never overflows. The adder and acc are W+2 bits.
- req_data is sampled only on the accept edge; later changes have no effect on the in-flight op.
- A requester dropping req_valid before being granted is legal; the arbiter rescans each cycle.
- rr_ptr changes only on accept; IDLE cycles with no request leave it unchanged.
- Reset mid-operation (ACC or DONE):
  - Immediate return to reset values.
  - The in-flight result is discarded and no response is produced.
- NREQ=1: grant is always 0 and rsp_id is always 0.

Test Plan:
- Single request, req0 a=1,b=2,c=3,d=4, rsp_ready=1 -> accept at edge k; rsp_valid=1 with rsp_sum=10, rsp_id=0 after edge k+3 for exactly 1 cycle; busy high over edges k..k+4.
- Max values, all operands 255 (W=8) -> rsp_sum=1020 (0x3FC), no truncation.
- Contention, req0 and req1 held valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; rsp_id sequence matches; accepts 5 cycles apart; each req_ready high only in IDLE.
- Backpressure, rsp_ready=0 for 6 cycles after rsp_valid -> rsp_sum and rsp_id stable, req_ready all 0 and no new accept; release rsp_ready -> handshake completes, next accept on the following edge.
- Operand change after accept, req0 data changed at edge k+1 -> the result reflects the latched values only.
- Reset during ACC at edge k+2 -> rsp_valid stays 0, busy=0, rr_ptr=0; the next request gets a clean result after 4 cycles.
